// File: rtl/chinpo_mem_pkg.sv
// Shared encodings and widths for the CHINPO data-memory responder.
package chinpo_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/chinpo_mem_array.sv
// Single-port word storage: synchronous write, combinational read so the
// responder can register ReadData itself on completion.
module chinpo_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // NOTE: storage has no reset; clearing every word would defeat RAM inference.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/chinpo_mem_responder.sv
// Data-memory responder: accepts one MemRead/MemWrite in IDLE, waits
// WAIT_CYCLES extra cycles, then commits and pulses MemReady for one cycle.
module chinpo_mem_responder
  import chinpo_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              Busy,
  output logic              Collide
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  op_t               op_q, op_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              collide_q, collide_d;
  logic              commit;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  chinpo_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .CLK   (CLK),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (mem_rdata)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    op_d       = op_q;
    readdata_d = readdata_q;
    collide_d  = 1'b0;
    commit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (MemRead ^ MemWrite) begin
          addr_d  = MemAddr;
          data_d  = WriteData;
          op_d    = MemWrite ? OP_WR : OP_RD;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = WAIT;
        end else if (MemRead && MemWrite) begin
          collide_d = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // The DONE entry edge is where the access actually happens.
          commit  = 1'b1;
          state_d = DONE;
          if (op_q == OP_RD) begin
            readdata_d = mem_rdata;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating with Reset keeps an in-flight write from landing during reset.
  assign mem_we = commit && (op_q == OP_WR) && !Reset;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      op_q       <= OP_RD;
      readdata_q <= '0;
      collide_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      op_q       <= op_d;
      readdata_q <= readdata_d;
      collide_q  <= collide_d;
    end
  end

  assign ReadData = readdata_q;
  assign MemReady = (state_q == DONE);
  assign Busy     = (state_q == WAIT) || (state_q == DONE);
  assign Collide  = collide_q;

endmodule

// File: tb/tb_chinpo_mem_responder.sv
// Bench for chinpo_mem_responder: a cycle table on a WAIT_CYCLES=2 instance,
// hand sequences for capture, reset, held strobe, and a WAIT_CYCLES=0 instance.
module tb_chinpo_mem_responder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        rd0, wr0, rd1, wr1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wd0, wd1, rdata0, rdata1;
  logic        ready0, busy0, col0, ready1, busy1, col1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  chinpo_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut0 (
    .CLK(CLK), .Reset(Reset), .MemRead(rd0), .MemWrite(wr0), .MemAddr(addr0),
    .WriteData(wd0), .ReadData(rdata0), .MemReady(ready0), .Busy(busy0), .Collide(col0)
  );

  chinpo_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut1 (
    .CLK(CLK), .Reset(Reset), .MemRead(rd1), .MemWrite(wr1), .MemAddr(addr1),
    .WriteData(wd1), .ReadData(rdata1), .MemReady(ready1), .Busy(busy1), .Collide(col1)
  );

  typedef struct {
    logic        rd, wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        ready, busy, collide;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, wr, input logic [7:0] a, input logic [15:0] d,
                              input logic rdy, bsy, col, input logic [15:0] rdat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
    v.ready = rdy; v.busy = bsy; v.collide = col; v.rdata = rdat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on dut0: strobe for the accept edge only, then drive junk
  // address/data while waiting; latency is counted in edges after accept.
  task automatic txn(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d,
                     input logic [7:0] ja, input logic [15:0] jd, input string name);
    int n;
    n = 0;
    @(negedge CLK); rd0 = rd; wr0 = wr; addr0 = a; wd0 = d;
    @(negedge CLK); rd0 = 1'b0; wr0 = 1'b0; addr0 = ja; wd0 = jd;
    check({name, "_busy"}, 32'(busy0), 32'd1);
    while (!ready0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_latency"}, n, 32'd3);
    @(negedge CLK);
    check({name, "_idle"}, {31'd0, busy0 | ready0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_ready;
    Reset = 1'b1;
    rd0 = 0; wr0 = 0; addr0 = 0; wd0 = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
    repeat (2) @(negedge CLK);
    check("reset_rdata", 32'(rdata0), 32'h0);
    check("reset_ready", 32'(ready0), 32'h0);
    check("reset_busy", 32'(busy0), 32'h0);
    check("reset_collide", 32'(col0), 32'h0);
    Reset = 1'b0;

    // Write BEEF@10, read it back, write 2222@20, collide on 20, read 20.
    vecs.push_back(mk(0,1,8'h10,16'hBEEF, 0,1,0,16'h0000));
    vecs.push_back(mk(0,0,8'h10,16'hBEEF, 0,1,0,16'h0000));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,1,0,16'h0000));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 1,1,0,16'h0000));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,16'h0000));
    vecs.push_back(mk(1,0,8'h10,16'h0000, 0,1,0,16'h0000));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,1,0,16'h0000));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,1,0,16'h0000));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 1,1,0,16'hBEEF));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,16'hBEEF));
    vecs.push_back(mk(0,1,8'h20,16'h2222, 0,1,0,16'hBEEF));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,1,0,16'hBEEF));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,1,0,16'hBEEF));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 1,1,0,16'hBEEF));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,16'hBEEF));
    vecs.push_back(mk(1,1,8'h20,16'hFFFF, 0,0,1,16'hBEEF));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,16'hBEEF));
    vecs.push_back(mk(1,0,8'h20,16'h0000, 0,1,0,16'hBEEF));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,1,0,16'hBEEF));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,1,0,16'hBEEF));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 1,1,0,16'h2222));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,16'h2222));

    @(negedge CLK);
    for (int i = 0; i < vecs.size(); i++) begin
      rd0 = vecs[i].rd; wr0 = vecs[i].wr; addr0 = vecs[i].addr; wd0 = vecs[i].wdata;
      @(negedge CLK);
      check($sformatf("vec%0d_ready", i), 32'(ready0), 32'(vecs[i].ready));
      check($sformatf("vec%0d_busy", i), 32'(busy0), 32'(vecs[i].busy));
      check($sformatf("vec%0d_collide", i), 32'(col0), 32'(vecs[i].collide));
      check($sformatf("vec%0d_rdata", i), 32'(rdata0), 32'(vecs[i].rdata));
    end
    rd0 = 0; wr0 = 0;

    // Captured address/data must survive bus changes during WAIT.
    txn(0, 1, 8'h7F, 16'h7777, 8'h00, 16'h0000, "pre_7f");
    txn(0, 1, 8'h03, 16'hA5A5, 8'h7F, 16'h0000, "wr_03");
    txn(1, 0, 8'h03, 16'h0000, 8'h55, 16'hFFFF, "rd_03");
    check("rd_03_data", 32'(rdata0), 32'hA5A5);
    txn(1, 0, 8'h7F, 16'h0000, 8'h03, 16'hFFFF, "rd_7f");
    check("rd_7f_data", 32'(rdata0), 32'h7777);

    // Reset during WAIT drops the pending write and clears outputs at once.
    txn(0, 1, 8'h08, 16'h1111, 8'h00, 16'h0000, "pre_08");
    txn(1, 0, 8'h08, 16'h0000, 8'h00, 16'h0000, "rd_08a");
    check("rd_08a_data", 32'(rdata0), 32'h1111);
    @(negedge CLK); wr0 = 1'b1; addr0 = 8'h08; wd0 = 16'h5555;
    @(negedge CLK); wr0 = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check("midrst_rdata", 32'(rdata0), 32'h0);
    check("midrst_ready", 32'(ready0), 32'h0);
    check("midrst_busy", 32'(busy0), 32'h0);
    @(negedge CLK); Reset = 1'b0;
    txn(1, 0, 8'h08, 16'h0000, 8'h00, 16'h0000, "rd_08b");
    check("rd_08b_data", 32'(rdata0), 32'h1111);

    // Held MemRead dropped on MemReady yields exactly one completion.
    @(negedge CLK); rd0 = 1'b1; addr0 = 8'h10;
    n_ready = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (ready0) begin
        n_ready++;
        rd0 = 1'b0;
      end
    end
    rd0 = 1'b0;
    check("hold_ready_count", n_ready, 32'd1);
    check("hold_rdata", 32'(rdata0), 32'hBEEF);
    check("hold_busy_end", 32'(busy0), 32'h0);

    // WAIT_CYCLES=0: MemReady one edge after accept.
    @(negedge CLK); wr1 = 1'b1; addr1 = 8'h05; wd1 = 16'h1234;
    @(negedge CLK); wr1 = 1'b0; addr1 = 8'h00; wd1 = 16'h0000;
    check("w0_wr_busy", 32'(busy1), 32'h1);
    check("w0_wr_ready_early", 32'(ready1), 32'h0);
    @(negedge CLK);
    check("w0_wr_ready", 32'(ready1), 32'h1);
    @(negedge CLK); rd1 = 1'b1; addr1 = 8'h05;
    @(negedge CLK); rd1 = 1'b0; addr1 = 8'h00;
    check("w0_rd_ready_early", 32'(ready1), 32'h0);
    @(negedge CLK);
    check("w0_rd_ready", 32'(ready1), 32'h1);
    check("w0_rd_data", 32'(rdata1), 32'h1234);
    @(negedge CLK);
    check("w0_idle", {31'd0, busy1 | ready1 | col1}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
